// File: rtl/car_selector_pkg.sv
// Shared car parameter set, selector FSM states and the index-to-parameters lookup
// used by the car selector and the IR packet generator.
package car_selector_pkg;

    typedef struct packed {
        logic [7:0] carrier_div;
        logic [7:0] header_len;
        logic [7:0] one_len;
        logic [7:0] zero_len;
    } CarSettings;

    localparam CarSettings BLUE_PARAMS   = '{8'd26, 8'd20, 8'd6, 8'd3};
    localparam CarSettings RED_PARAMS    = '{8'd28, 8'd24, 8'd7, 8'd4};
    localparam CarSettings GREEN_PARAMS  = '{8'd30, 8'd28, 8'd8, 8'd5};
    localparam CarSettings YELLOW_PARAMS = '{8'd32, 8'd32, 8'd9, 8'd6};

    // Number of cars that have a parameter set defined above.
    localparam int DEFINED_CARS = 4;

    typedef enum logic [1:0] {
        MANUAL_IDLE,
        MANUAL_PENDING,
        SCAN
    } car_sel_state_t;

    // Indices without a defined parameter set fall back to the blue car.
    function automatic CarSettings car_params(input logic [31:0] idx);
        case (idx)
            32'd0:   return BLUE_PARAMS;
            32'd1:   return RED_PARAMS;
            32'd2:   return GREEN_PARAMS;
            32'd3:   return YELLOW_PARAMS;
            default: return BLUE_PARAMS;
        endcase
    endfunction

endpackage

// File: rtl/car_selector_switch_debouncer.sv
// Two-flop synchroniser plus stability counter for a bank of board switches;
// values above MAX_VALID are never published on the debounced output.
module switch_debouncer #(
    parameter int          WIDTH           = 2,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_VALID       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] debounced
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] count;

    // NOTE: reset is sampled on the clock edge only (synchronous, active-low), and
    // every flop here uses non-blocking assignment so the two sync stages really
    // are two separate registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            candidate <= '0;
            count     <= '0;
            debounced <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 != candidate) begin
                candidate <= sync_q2;
                count     <= '0;
            end else if (count == CNT_LIMIT) begin
                if (32'(candidate) <= MAX_VALID) begin
                    debounced <= candidate;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_selector.sv
// Registered car selector: debounced manual selection or auto-scan, committed
// only on IR packet boundaries so a packet never mixes car parameters.
module car_selector
    import car_selector_pkg::*;
#(
    parameter  int CAR_COUNT       = DEFINED_CARS,
    parameter  int DEBOUNCE_CYCLES = 1_000_000,
    localparam int SEL_W           = $clog2(CAR_COUNT)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [SEL_W-1:0]     SWITCHES,
    input  logic                 SCAN_EN,
    input  logic                 PACKET_DONE,
    output CarSettings           SELECTED_CAR,
    output logic [SEL_W-1:0]     CAR_IDX,
    output logic [CAR_COUNT-1:0] LEDS,
    output logic                 CHANGED
);

    localparam logic [SEL_W-1:0]     LAST_IDX = SEL_W'(CAR_COUNT - 1);
    localparam logic [CAR_COUNT-1:0] LED_ONE  = CAR_COUNT'(1);

    car_sel_state_t   state;
    car_sel_state_t   state_next;
    logic [SEL_W-1:0] debounced;
    logic [SEL_W-1:0] idx_next;
    logic             commit;

    switch_debouncer #(
        .WIDTH           (SEL_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MAX_VALID       (CAR_COUNT - 1)
    ) u_debouncer (
        .clk       (CLK),
        .rst_n     (RESET),
        .raw       (SWITCHES),
        .debounced (debounced)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = CAR_IDX;
        commit     = 1'b0;

        if (PACKET_DONE) begin
            case (state)
                MANUAL_PENDING: begin
                    idx_next = debounced;
                    commit   = 1'b1;
                end
                SCAN: begin
                    idx_next = (CAR_IDX == LAST_IDX) ? '0 : CAR_IDX + 1'b1;
                    commit   = 1'b1;
                end
                default: ;
            endcase
        end

        // Compare against the post-commit index so a just-served selection
        // does not linger in MANUAL_PENDING for an extra cycle.
        if (SCAN_EN) begin
            state_next = SCAN;
        end else if (debounced != idx_next) begin
            state_next = MANUAL_PENDING;
        end else begin
            state_next = MANUAL_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= MANUAL_IDLE;
            CAR_IDX      <= '0;
            SELECTED_CAR <= BLUE_PARAMS;
            LEDS         <= LED_ONE;
            CHANGED      <= 1'b0;
        end else begin
            state   <= state_next;
            CHANGED <= commit;
            if (commit) begin
                CAR_IDX      <= idx_next;
                SELECTED_CAR <= car_params(32'(idx_next));
                LEDS         <= LED_ONE << idx_next;
            end
        end
    end

endmodule

// File: tb/tb_car_selector.sv
// Directed self-checking bench for car_selector: a 4-car instance for the main
// scenarios and a 3-car instance for out-of-range switch rejection.
module tb_car_selector;
    import car_selector_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] SWITCHES;
    logic       SCAN_EN;
    logic       PACKET_DONE;

    CarSettings sel4;
    logic [1:0] idx4;
    logic [3:0] leds4;
    logic       changed4;

    CarSettings sel3;
    logic [1:0] idx3;
    logic [2:0] leds3;
    logic       changed3;

    int checks   = 0;
    int failures = 0;

    car_selector #(.CAR_COUNT(4), .DEBOUNCE_CYCLES(4)) dut4 (
        .CLK          (CLK),
        .RESET        (RESET),
        .SWITCHES     (SWITCHES),
        .SCAN_EN      (SCAN_EN),
        .PACKET_DONE  (PACKET_DONE),
        .SELECTED_CAR (sel4),
        .CAR_IDX      (idx4),
        .LEDS         (leds4),
        .CHANGED      (changed4)
    );

    car_selector #(.CAR_COUNT(3), .DEBOUNCE_CYCLES(4)) dut3 (
        .CLK          (CLK),
        .RESET        (RESET),
        .SWITCHES     (SWITCHES),
        .SCAN_EN      (SCAN_EN),
        .PACKET_DONE  (PACKET_DONE),
        .SELECTED_CAR (sel3),
        .CAR_IDX      (idx3),
        .LEDS         (leds3),
        .CHANGED      (changed3)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_packet();
        PACKET_DONE = 1'b1;
        tick();
        PACKET_DONE = 1'b0;
    endtask

    task automatic apply_reset();
        RESET       = 1'b0;
        PACKET_DONE = 1'b0;
        repeat (2) tick();
        RESET = 1'b1;
    endtask

    int scan_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        SWITCHES    = 2'b00;
        SCAN_EN     = 1'b0;
        PACKET_DONE = 1'b0;
        RESET       = 1'b0;
        tick();

        // Reset state
        apply_reset();
        check("reset_idx",     64'(idx4),     64'd0);
        check("reset_leds",    64'(leds4),    64'b0001);
        check("reset_sel",     64'(sel4),     64'(BLUE_PARAMS));
        check("reset_changed", 64'(changed4), 64'd0);

        // Manual commit waits for the packet boundary
        SWITCHES = 2'b10;
        repeat (10) tick();
        check("manual_hold_idx", 64'(idx4), 64'd0);
        pulse_packet();
        check("manual_idx",     64'(idx4),     64'd2);
        check("manual_sel",     64'(sel4),     64'(GREEN_PARAMS));
        check("manual_leds",    64'(leds4),    64'b0100);
        check("manual_changed", 64'(changed4), 64'd1);
        tick();
        check("manual_changed_drop", 64'(changed4), 64'd0);
        check("manual_idx_kept",     64'(idx4),     64'd2);

        // Bounce rejection
        SWITCHES = 2'b00;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            SWITCHES = (i % 2 == 0) ? 2'b01 : 2'b00;
            repeat (2) tick();
        end
        SWITCHES = 2'b00;
        repeat (10) tick();
        pulse_packet();
        check("bounce_idx",     64'(idx4),     64'd0);
        check("bounce_changed", 64'(changed4), 64'd0);

        // Scan wrap
        apply_reset();
        SCAN_EN = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            pulse_packet();
            check($sformatf("scan_idx_%0d", i),     64'(idx4),     64'(scan_exp[i]));
            check($sformatf("scan_changed_%0d", i), 64'(changed4), 64'd1);
            check($sformatf("scan_leds_%0d", i),    64'(leds4),    64'(4'b0001 << scan_exp[i]));
            repeat (4) tick();
            check($sformatf("scan_changed_low_%0d", i), 64'(changed4), 64'd0);
        end
        SCAN_EN = 1'b0;

        // Out-of-range switch value on the 3-car instance
        apply_reset();
        SWITCHES = 2'b11;
        repeat (10) tick();
        pulse_packet();
        check("invalid_idx",     64'(idx3),     64'd0);
        check("invalid_changed", 64'(changed3), 64'd0);
        check("invalid_leds",    64'(leds3),    64'b001);

        // Reset coincident with a packet boundary discards the pending selection
        apply_reset();
        SWITCHES = 2'b11;
        repeat (10) tick();
        check("pending_idx", 64'(idx4), 64'd0);
        RESET       = 1'b0;
        PACKET_DONE = 1'b1;
        tick();
        RESET       = 1'b1;
        PACKET_DONE = 1'b0;
        check("rst_pend_idx",     64'(idx4),     64'd0);
        check("rst_pend_changed", 64'(changed4), 64'd0);
        check("rst_pend_leds",    64'(leds4),    64'b0001);
        check("rst_pend_sel",     64'(sel4),     64'(BLUE_PARAMS));

        // Debounce restarts after reset; a later packet then commits car 3
        repeat (10) tick();
        pulse_packet();
        check("post_reset_idx",     64'(idx4),     64'd3);
        check("post_reset_sel",     64'(sel4),     64'(YELLOW_PARAMS));
        check("post_reset_changed", 64'(changed4), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
